encoder_4x2: RTL and testbench
==============================

Name: encoder_4x2

Overview:
Registered 4-to-2 binary encoder with valid and multi-hot error flags, plus a saturating output-toggle counter.
It converts a 4-bit one-hot request vector into its 2-bit index.
Used as a small leaf datapath block in the power-estimation datapath. The toggle counter feeds switching-activity statistics to the estimator.

Parameters:
CNT_W, 16, width of the output toggle counter (2..32)
MSB_PRIORITY, 1, multi-hot resolution: 1 = highest set bit wins, 0 = lowest set bit wins

Ports:
clk  in  1  system clock, rising-edge
rst  in  1  asynchronous, active-high reset
d  in  4  request vector, nominally one-hot
cnt_clr  in  1  synchronous clear of toggle_cnt
out  out  2  encoded index of the selected bit of d (registered)
valid  out  1  at least one bit of d was set (registered)
multi_hot  out  1  more than one bit of d was set (registered)
toggle_cnt  out  CNT_W  accumulated count of bit flips on out

Behaviour:
- Reset (async assert, sync release): out=2'b00, valid=0, multi_hot=0, toggle_cnt=0.
- Latency: all outputs update on the rising clk edge after d is sampled; 1-cycle latency, no handshake, new input every cycle.
- One-hot encoding:
  - d=0001 -> out=0
  - d=0010 -> out=1
  - d=0100 -> out=2
  - d=1000 -> out=3
  - valid=1, multi_hot=0.
- d=0000: out=00, valid=0, multi_hot=0. out is forced to 0 and does not hold its previous value.
- Multi-hot d:
  - out = index of highest set bit when MSB_PRIORITY=1, lowest set bit when MSB_PRIORITY=0.
  - valid=1, multi_hot=1.
- Toggle counting:
  - Each cycle, compute popcount(out_next XOR out_current), value 0..2.
  - Add it to toggle_cnt on the same edge that updates out.
  - toggle_cnt saturates at 2^CNT_W-1 and never wraps.
- cnt_clr=1 sets toggle_cnt to 0 on that edge and discards that cycle's increment. cnt_clr has priority over the increment. out, valid and multi_hot update normally during cnt_clr.
- Reset mid-operation: all registers clear immediately, regardless of clk.
- No X propagation from d to the registers is required; d is expected to be known.

Decomposition:
- Shared package holds:
  - the index-width constant (2)
  - a function for popcount of a 2-bit vector
  - the encode function (one-hot/priority to index), reused by wider encoders.
- One natural sub-module, encoder_4x2_prio_comb: purely combinational d -> {idx, any, multi}, parameterized by MSB_PRIORITY. The top level adds the registers and the toggle counter.

Test Plan:
- Reset: assert rst with d=1000 mid-cycle -> out=0, valid=0, multi_hot=0, toggle_cnt=0 immediately; outputs stay at reset values while rst=1.
- One-hot sweep, one value per cycle: d = 0000,0001,0010,0100,1000,0010,0100,0010,1000.
  - out (1 cycle later) = 0,0,1,2,3,1,2,1,3.
  - valid = 0,1,1,1,1,1,1,1,1.
  - toggle_cnt = 10 after the final edge.
- Multi-hot with MSB_PRIORITY=1: d=0110 -> out=2, valid=1, multi_hot=1. d=1111 -> out=3. With MSB_PRIORITY=0: d=0110 -> out=1, d=1111 -> out=0.
- Zero after nonzero: d=1000 then d=0000 -> out 3 then 0, valid 1 then 0, toggle_cnt +2.
- Counter clear: toggle_cnt=10, assert cnt_clr for one cycle while out changes 3->1 -> toggle_cnt=0 (increment dropped); next change 1->2 -> toggle_cnt=2.
- Saturation with CNT_W=2: alternate d=0001/1000 (out 0<->3, +2 per cycle) -> toggle_cnt reaches 3 and holds at 3.

Source files
------------

// File: rtl/encoder_4x2_pkg.sv
// Shared constants and helper functions for the 4-to-2 encoder family.
package encoder_4x2_pkg;

  localparam int REQ_W = 4;  // request vector width
  localparam int IDX_W = 2;  // encoded index width

  // Number of set bits in a 2-bit vector (0..2).
  function automatic logic [1:0] popcount2(input logic [1:0] v);
    return {1'b0, v[1]} + {1'b0, v[0]};
  endfunction

  // Index of the winning set bit of req; msb_first selects which end wins
  // when several bits are set. Returns 0 for an all-zero request.
  function automatic logic [IDX_W-1:0] encode(input logic [REQ_W-1:0] req,
                                              input bit msb_first);
    logic [IDX_W-1:0] idx;
    idx = '0;
    if (msb_first) begin
      // Ascending scan: the last (highest) set bit overwrites earlier ones.
      for (int i = 0; i < REQ_W; i++) begin
        if (req[i]) idx = IDX_W'(i);
      end
    end else begin
      // Descending scan: the last (lowest) set bit overwrites earlier ones.
      for (int i = REQ_W - 1; i >= 0; i--) begin
        if (req[i]) idx = IDX_W'(i);
      end
    end
    return idx;
  endfunction

endpackage : encoder_4x2_pkg

// File: rtl/encoder_4x2_prio_comb.sv
// Purely combinational priority encoder: request vector -> {index, any, multi}.
module encoder_4x2_prio_comb
  import encoder_4x2_pkg::*;
#(
  parameter int MSB_PRIORITY = 1
) (
  input  logic [REQ_W-1:0] req_i,
  output logic [IDX_W-1:0] idx_o,
  output logic             any_o,
  output logic             multi_o
);

  // Decode index and presence flags from the raw request.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
    idx_o   = '0;
    any_o   = 1'b0;
    multi_o = 1'b0;
    any_o   = |req_i;
    // Clearing the lowest set bit leaves something behind only if 2+ bits were set.
    multi_o = |(req_i & (req_i - REQ_W'(1)));
    idx_o   = encode(req_i, MSB_PRIORITY != 0);
  end

endmodule : encoder_4x2_prio_comb

// File: rtl/encoder_4x2.sv
// Registered 4-to-2 encoder with valid / multi-hot flags and a saturating
// counter of bit flips on the registered index.
module encoder_4x2
  import encoder_4x2_pkg::*;
#(
  parameter int CNT_W        = 16,
  parameter int MSB_PRIORITY = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [REQ_W-1:0] d,
  input  logic             cnt_clr,
  output logic [IDX_W-1:0] out,
  output logic             valid,
  output logic             multi_hot,
  output logic [CNT_W-1:0] toggle_cnt
);

  localparam int SUM_W = CNT_W + 1;

  logic [IDX_W-1:0] idx_d, out_q;
  logic             valid_d, valid_q;
  logic             multi_d, multi_q;
  logic [CNT_W-1:0] cnt_d, cnt_q;
  logic [SUM_W-1:0] cnt_sum;

  encoder_4x2_prio_comb #(
    .MSB_PRIORITY(MSB_PRIORITY)
  ) u_prio (
    .req_i  (d),
    .idx_o  (idx_d),
    .any_o  (valid_d),
    .multi_o(multi_d)
  );

  // Next toggle count: clear wins, else add flipped bits and saturate.
  always_comb begin
    cnt_sum = {1'b0, cnt_q} + SUM_W'(popcount2(idx_d ^ out_q));
    cnt_d   = cnt_q;
    if (cnt_clr) begin
      cnt_d = '0;
    end else if (cnt_sum[CNT_W]) begin
      cnt_d = '1;
    end else begin
      cnt_d = cnt_sum[CNT_W-1:0];
    end
  end

  // Output and counter registers, cleared asynchronously by rst.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: non-blocking assignments so every register samples pre-edge values.
    if (rst) begin
      out_q   <= '0;
      valid_q <= 1'b0;
      multi_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      out_q   <= idx_d;
      valid_q <= valid_d;
      multi_q <= multi_d;
      cnt_q   <= cnt_d;
    end
  end

  assign out        = out_q;
  assign valid      = valid_q;
  assign multi_hot  = multi_q;
  assign toggle_cnt = cnt_q;

endmodule : encoder_4x2

// File: tb/tb_encoder_4x2.sv
// Directed testbench for encoder_4x2: MSB-priority, LSB-priority and a
// narrow-counter instance share the same stimulus.
module tb_encoder_4x2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  d = 4'b0000;
  logic        cnt_clr = 1'b0;

  logic [1:0]  m_out, l_out, s_out;
  logic        m_valid, l_valid, s_valid;
  logic        m_multi, l_multi, s_multi;
  logic [15:0] m_cnt, l_cnt;
  logic [1:0]  s_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  encoder_4x2 #(.CNT_W(16), .MSB_PRIORITY(1)) u_msb (
    .clk(clk), .rst(rst), .d(d), .cnt_clr(cnt_clr),
    .out(m_out), .valid(m_valid), .multi_hot(m_multi), .toggle_cnt(m_cnt)
  );

  encoder_4x2 #(.CNT_W(16), .MSB_PRIORITY(0)) u_lsb (
    .clk(clk), .rst(rst), .d(d), .cnt_clr(cnt_clr),
    .out(l_out), .valid(l_valid), .multi_hot(l_multi), .toggle_cnt(l_cnt)
  );

  encoder_4x2 #(.CNT_W(2), .MSB_PRIORITY(1)) u_sat (
    .clk(clk), .rst(rst), .d(d), .cnt_clr(cnt_clr),
    .out(s_out), .valid(s_valid), .multi_hot(s_multi), .toggle_cnt(s_cnt)
  );

  // Sweep stimulus and expected results (one entry per cycle).
  logic [3:0] sweep_d   [9] = '{4'b0000, 4'b0001, 4'b0010, 4'b0100, 4'b1000,
                                4'b0010, 4'b0100, 4'b0010, 4'b1000};
  logic [1:0] sweep_out [9] = '{2'd0, 2'd0, 2'd1, 2'd2, 2'd3, 2'd1, 2'd2, 2'd1, 2'd3};
  logic       sweep_vld [9] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};

  // Advance one clock and settle just past the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    step();
    rst = 1'b0;
    d   = 4'b1000;
    step();
    n_checks++;
    if (m_out !== 2'd3 || m_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL pre_reset out=%0d valid=%0b expected out=3 valid=1", m_out, m_valid);
    end
    #2 rst = 1'b1;   // mid-cycle, clk still high
    #1;
    n_checks++;
    if (m_out !== 2'd0 || m_valid !== 1'b0 || m_multi !== 1'b0 || m_cnt !== 16'd0) begin
      n_fail++;
      $display("FAIL async_reset out=%0d valid=%0b multi=%0b cnt=%0d expected all 0",
               m_out, m_valid, m_multi, m_cnt);
    end
    step();
    n_checks++;
    if (m_out !== 2'd0 || m_valid !== 1'b0 || m_multi !== 1'b0 || m_cnt !== 16'd0 ||
        s_cnt !== 2'd0) begin
      n_fail++;
      $display("FAIL reset_hold out=%0d valid=%0b multi=%0b cnt=%0d scnt=%0d expected all 0",
               m_out, m_valid, m_multi, m_cnt, s_cnt);
    end
    rst = 1'b0;
    d   = 4'b0000;
  endtask

  task automatic test_onehot_sweep();
    for (int i = 0; i < 9; i++) begin
      d = sweep_d[i];
      step();
      n_checks++;
      if (m_out !== sweep_out[i] || m_valid !== sweep_vld[i] || m_multi !== 1'b0 ||
          l_out !== sweep_out[i]) begin
        n_fail++;
        $display("FAIL sweep[%0d] d=%b out=%0d lout=%0d valid=%0b multi=%0b expected out=%0d valid=%0b multi=0",
                 i, sweep_d[i], m_out, l_out, m_valid, m_multi, sweep_out[i], sweep_vld[i]);
      end
    end
    n_checks++;
    if (m_cnt !== 16'd10) begin
      n_fail++;
      $display("FAIL sweep_toggle_cnt got=%0d expected=10", m_cnt);
    end
  endtask

  task automatic test_multi_hot();
    d = 4'b0110;
    step();
    n_checks++;
    if (m_out !== 2'd2 || m_valid !== 1'b1 || m_multi !== 1'b1 ||
        l_out !== 2'd1 || l_valid !== 1'b1 || l_multi !== 1'b1) begin
      n_fail++;
      $display("FAIL multi_0110 msb(out=%0d v=%0b m=%0b) lsb(out=%0d v=%0b m=%0b) expected msb(2,1,1) lsb(1,1,1)",
               m_out, m_valid, m_multi, l_out, l_valid, l_multi);
    end
    n_checks++;
    if (m_cnt !== 16'd11) begin
      n_fail++;
      $display("FAIL multi_0110_cnt got=%0d expected=11", m_cnt);
    end
    d = 4'b1111;
    step();
    n_checks++;
    if (m_out !== 2'd3 || l_out !== 2'd0 || m_multi !== 1'b1 || l_multi !== 1'b1) begin
      n_fail++;
      $display("FAIL multi_1111 msb_out=%0d lsb_out=%0d multi=%0b/%0b expected 3 0 1/1",
               m_out, l_out, m_multi, l_multi);
    end
    n_checks++;
    if (m_cnt !== 16'd12) begin
      n_fail++;
      $display("FAIL multi_1111_cnt got=%0d expected=12", m_cnt);
    end
  endtask

  task automatic test_zero_after_nonzero();
    d = 4'b1000;
    step();
    n_checks++;
    if (m_out !== 2'd3 || m_valid !== 1'b1 || m_multi !== 1'b0 || m_cnt !== 16'd12) begin
      n_fail++;
      $display("FAIL zero_pre out=%0d valid=%0b multi=%0b cnt=%0d expected 3 1 0 12",
               m_out, m_valid, m_multi, m_cnt);
    end
    d = 4'b0000;
    step();
    n_checks++;
    if (m_out !== 2'd0 || m_valid !== 1'b0 || m_multi !== 1'b0 || m_cnt !== 16'd14) begin
      n_fail++;
      $display("FAIL zero_post out=%0d valid=%0b multi=%0b cnt=%0d expected 0 0 0 14",
               m_out, m_valid, m_multi, m_cnt);
    end
  endtask

  task automatic test_cnt_clr();
    d = 4'b1000;
    step();
    n_checks++;
    if (m_out !== 2'd3 || m_cnt !== 16'd16) begin
      n_fail++;
      $display("FAIL clr_pre out=%0d cnt=%0d expected 3 16", m_out, m_cnt);
    end
    d       = 4'b0010;
    cnt_clr = 1'b1;
    step();
    n_checks++;
    if (m_out !== 2'd1 || m_valid !== 1'b1 || m_cnt !== 16'd0) begin
      n_fail++;
      $display("FAIL clr_edge out=%0d valid=%0b cnt=%0d expected 1 1 0", m_out, m_valid, m_cnt);
    end
    cnt_clr = 1'b0;
    d       = 4'b0100;
    step();
    n_checks++;
    if (m_out !== 2'd2 || m_cnt !== 16'd2) begin
      n_fail++;
      $display("FAIL clr_after out=%0d cnt=%0d expected 2 2", m_out, m_cnt);
    end
  endtask

  task automatic test_saturation();
    logic [1:0]  exp_s [6] = '{2'd0, 2'd2, 2'd3, 2'd3, 2'd3, 2'd3};
    logic [15:0] exp_m [6] = '{16'd0, 16'd2, 16'd4, 16'd6, 16'd8, 16'd10};
    d   = 4'b0000;
    rst = 1'b1;
    #1 rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      d = (i % 2 == 0) ? 4'b0001 : 4'b1000;
      step();
      n_checks++;
      if (s_cnt !== exp_s[i] || m_cnt !== exp_m[i]) begin
        n_fail++;
        $display("FAIL sat[%0d] sat_cnt=%0d wide_cnt=%0d expected %0d %0d",
                 i, s_cnt, m_cnt, exp_s[i], exp_m[i]);
      end
    end
    d       = 4'b0001;
    cnt_clr = 1'b1;
    step();
    cnt_clr = 1'b0;
    n_checks++;
    if (s_cnt !== 2'd0 || s_out !== 2'd0) begin
      n_fail++;
      $display("FAIL sat_clr sat_cnt=%0d out=%0d expected 0 0", s_cnt, s_out);
    end
  endtask

  initial begin
    test_reset();
    test_onehot_sweep();
    test_multi_hot();
    test_zero_after_nonzero();
    test_cnt_clr();
    test_saturation();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule : tb_encoder_4x2
